barrel_out_framer: RTL and testbench

Output framing stage downstream of the barrel-projection memory interface. Buffers the corrected pixel stream in a small FIFO and re-emits it as an AXI4-Stream video stream for the output VDMA. Generates `m_tuser` (start of frame) and `m_tlast` (end of line) from raster counters that advance on output handshakes. Isolates the memory interface from VDMA backpressure.

---
 rtl/barrel_pkg.sv | 19 +
 rtl/framer_fifo.sv | 78 +++++++
 rtl/barrel_out_framer.sv | 141 ++++++++++++++
 tb/tb_barrel_out_framer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// barrel_pkg
// Constants and types shared by the barrel-projection output path
// (memory interface, math blocks, output framer).
//   BARREL_WIDTH / BARREL_HEIGHT : default active raster size
//   PIXEL_W / pixel_t            : corrected pixel format
package barrel_pkg;

  localparam int BARREL_WIDTH  = 1080;
  localparam int BARREL_HEIGHT = 960;
  localparam int PIXEL_W       = 16;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Counter width for a raster dimension; never narrower than one bit.
  function automatic int raster_bits(input int extent);
    return (extent > 1) ? $clog2(extent) : 1;
  endfunction

endpackage

// File: rtl/framer_fifo.sv
// framer_fifo
// Synchronous FIFO, read/write pointers plus occupancy count.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (flushes contents)
//   push, wr_data   : write request and data; ignored while full
//   pop             : read request; ignored while empty
//   head            : entry at the read pointer (valid when !empty)
//   full, empty     : occupancy flags, registered-state only
// FIFO_DEPTH must be a power of two so pointers wrap naturally.
module framer_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/barrel_out_framer.sv
// barrel_out_framer
// Buffers the corrected pixel stream and re-emits it as AXI4-Stream video
// (tuser = start of frame, tlast = end of line) towards the output VDMA.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tready  : pixel input from the memory interface
//   m_tdata/m_tvalid/m_tready  : AXIS video output
//   m_tuser, m_tlast           : frame start / line end, qualified by m_tvalid
//   frame_done                 : one-cycle pulse after the last pixel of a frame
//   frame_count, stall_cycles  : statistics, present only when the macro
//                                BARREL_FRAMER_STATS_EN is defined
// All outputs derive from registered state; no input-to-output comb paths.
module barrel_out_framer
  import barrel_pkg::*;
#(
  parameter int WIDTH      = BARREL_WIDTH,
  parameter int HEIGHT     = BARREL_HEIGHT,
  parameter int DATA_W     = PIXEL_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              frame_done
`ifdef BARREL_FRAMER_STATS_EN
  ,
  output logic [15:0]       frame_count,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int XW = raster_bits(WIDTH);
  localparam int YW = raster_bits(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              push, pop;
  logic              x_at_last, y_at_last;

  // Low during reset and for the first edge after it, so s_tready is
  // registered and rises one cycle after reset is released.
  logic              rst_done_q, rst_done_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              frame_done_q, frame_done_d;

  framer_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (s_tdata),
    .pop     (pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign s_tready   = rst_done_q && !fifo_full;
  assign m_tvalid   = !fifo_empty;
  // Storage is not reset, so mask the head to keep m_tdata at 0 when idle.
  assign m_tdata    = fifo_empty ? '0 : fifo_head;
  assign push       = s_tvalid && s_tready;
  assign pop        = m_tvalid && m_tready;

  assign x_at_last  = (x_q == X_LAST);
  assign y_at_last  = (y_q == Y_LAST);
  assign m_tuser    = m_tvalid && (x_q == '0) && (y_q == '0);
  assign m_tlast    = m_tvalid && x_at_last;
  assign frame_done = frame_done_q;

  always_comb begin
    rst_done_d   = 1'b1;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = pop && x_at_last && y_at_last;
    if (pop) begin
      if (x_at_last) begin
        x_d = '0;
        y_d = y_at_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_done_q   <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rst_done_q   <= rst_done_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef BARREL_FRAMER_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    frame_count_d  = frame_count_q;
    stall_cycles_d = stall_cycles_q;
    if (frame_done_q) begin
      frame_count_d = frame_count_q + 16'd1;
    end
    if (m_tvalid && !m_tready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      frame_count_q  <= frame_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign frame_count  = frame_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_barrel_out_framer.sv
module tb_barrel_out_framer;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int FRAME = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tuser;
  logic          m_tlast;
  logic          frame_done;
`ifdef BARREL_FRAMER_STATS_EN
  logic [15:0]   frame_count;
  logic [31:0]   stall_cycles;
`endif

  barrel_out_framer #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tuser      (m_tuser),
    .m_tlast      (m_tlast),
    .frame_done   (frame_done)
`ifdef BARREL_FRAMER_STATS_EN
    ,
    .frame_count  (frame_count),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain queue of accepted pixels plus a count of output
  // beats since reset; raster position is beat index modulo the frame size.
  logic [DW-1:0] model_q[$];
  int            beats_out;
  bit            fd_pending;
  int            in_val;
  int            stall_model;
  int            frame_model;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    model_q.delete();
    beats_out   = 0;
    fd_pending  = 1'b0;
    in_val      = 0;
    stall_model = 0;
    frame_model = 0;
  endtask

  // Drives random traffic and checks every cycle against the model until
  // max_out beats have left the DUT. Ready is forced low in the window
  // [stall_from, stall_from+stall_len).
  task automatic run_traffic(input int max_in, input int max_out,
                             input int valid_pct, input int ready_pct,
                             input int stall_from, input int stall_len);
    int  cyc;
    bit  do_pop, do_push;
    int  pos;
    for (cyc = 0; cyc < 4000; cyc++) begin
      checks++;
      if (frame_done !== fd_pending) begin
        failures++;
        $display("FAIL frame_done beat=%0d got=%b exp=%b", beats_out, frame_done, fd_pending);
      end
`ifdef BARREL_FRAMER_STATS_EN
      checks++;
      if (frame_count !== 16'(frame_model)) begin
        failures++;
        $display("FAIL frame_count got=%0d exp=%0d", frame_count, frame_model);
      end
      checks++;
      if (stall_cycles !== 32'(stall_model)) begin
        failures++;
        $display("FAIL stall_cycles got=%0d exp=%0d", stall_cycles, stall_model);
      end
`endif
      if (fd_pending) frame_model++;
      checks++;
      if (m_tvalid !== (model_q.size() != 0)) begin
        failures++;
        $display("FAIL m_tvalid got=%b exp_count=%0d", m_tvalid, model_q.size());
      end
      checks++;
      if (s_tready !== (model_q.size() != DEPTH)) begin
        failures++;
        $display("FAIL s_tready got=%b exp_count=%0d", s_tready, model_q.size());
      end
      pos = beats_out % FRAME;
      if (model_q.size() != 0) begin
        checks++;
        if (m_tdata !== model_q[0]) begin
          failures++;
          $display("FAIL m_tdata beat=%0d got=%0h exp=%0h", beats_out, m_tdata, model_q[0]);
        end
        checks++;
        if (m_tuser !== (pos == 0)) begin
          failures++;
          $display("FAIL m_tuser beat=%0d got=%b exp=%b", beats_out, m_tuser, pos == 0);
        end
        checks++;
        if (m_tlast !== ((pos % W) == W - 1)) begin
          failures++;
          $display("FAIL m_tlast beat=%0d got=%b exp=%b", beats_out, m_tlast, (pos % W) == W - 1);
        end
      end else begin
        checks++;
        if ({m_tuser, m_tlast} !== 2'b00) begin
          failures++;
          $display("FAIL idle_flags got=%b%b exp=00", m_tuser, m_tlast);
        end
      end
      if (beats_out >= max_out) break;

      if (cyc >= stall_from && cyc < stall_from + stall_len) m_tready = 1'b0;
      else m_tready = ($urandom_range(99, 0) < ready_pct);
      s_tvalid = (in_val < max_in) && ($urandom_range(99, 0) < valid_pct);
      s_tdata  = DW'(in_val);

      do_pop  = (model_q.size() != 0) && m_tready;
      do_push = s_tvalid && (model_q.size() != DEPTH);
      if ((model_q.size() != 0) && !m_tready) stall_model++;
      fd_pending = do_pop && (pos == FRAME - 1);
      if (do_pop) begin
        void'(model_q.pop_front());
        beats_out++;
      end
      if (do_push) begin
        model_q.push_back(s_tdata);
        in_val++;
      end
      step();
    end
    if (cyc >= 4000) begin
      checks++;
      failures++;
      $display("FAIL traffic_timeout beats=%0d exp=%0d", beats_out, max_out);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 16'hBEEF;
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({s_tready, m_tvalid, m_tdata, m_tuser, m_tlast, frame_done} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%b%b_%0h_%b%b%b exp=0", i, s_tready,
                 m_tvalid, m_tdata, m_tuser, m_tlast, frame_done);
      end
`ifdef BARREL_FRAMER_STATS_EN
      checks++;
      if ({frame_count, stall_cycles} !== '0) begin
        failures++;
        $display("FAIL reset_stats got=%0d/%0d exp=0/0", frame_count, stall_cycles);
      end
`endif
    end
    reset = 1'b0;
    step();
    checks++;
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b exp=1", s_tready);
    end
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL valid_after_reset got=%b exp=0", m_tvalid);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    m_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = DW'(i);
      step();
      checks++;
      if (s_tready !== (i != DEPTH - 1)) begin
        failures++;
        $display("FAIL fill_ready push=%0d got=%b exp=%b", i, s_tready, i != DEPTH - 1);
      end
      checks++;
      if (m_tdata !== '0 || m_tvalid !== 1'b1) begin
        failures++;
        $display("FAIL fill_head push=%0d got=%0h/%b exp=0/1", i, m_tdata, m_tvalid);
      end
    end
    // Input stays valid during the first pop: the full FIFO must refuse it.
    s_tdata  = 16'h00AA;
    m_tready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (m_tdata !== DW'(i)) begin
        failures++;
        $display("FAIL drain_data idx=%0d got=%0h exp=%0h", i, m_tdata, i);
      end
      step();
      if (i == 0) begin
        checks++;
        if (s_tready !== 1'b1) begin
          failures++;
          $display("FAIL drain_ready got=%b exp=1", s_tready);
        end
        s_tvalid = 1'b0;
      end
    end
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty got=%b exp=0", m_tvalid);
    end
  endtask

  task automatic test_framing();
    do_reset();
    run_traffic(2 * FRAME, 2 * FRAME, 100, 100, 0, 0);
  endtask

  task automatic test_random_backpressure();
    do_reset();
    run_traffic(3 * FRAME, 3 * FRAME, 80, 45, 0, 0);
    do_reset();
    run_traffic(3 * FRAME, 3 * FRAME, 60, 80, 0, 0);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    run_traffic(9, 5, 100, 100, 0, 0);
    reset    = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 16'h5555;
    m_tready = 1'b1;
    step();
    checks++;
    if ({m_tvalid, s_tready} !== 2'b00) begin
      failures++;
      $display("FAIL midreset_flags got=%b%b exp=00", m_tvalid, s_tready);
    end
    reset    = 1'b0;
    s_tvalid = 1'b0;
    step();
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_flush got=%b exp=0", m_tvalid);
    end
    s_tvalid = 1'b1;
    s_tdata  = 16'h1234;
    m_tready = 1'b0;
    step();
    s_tvalid = 1'b0;
    checks++;
    if ({m_tvalid, m_tuser, m_tlast} !== 3'b110 || m_tdata !== 16'h1234) begin
      failures++;
      $display("FAIL midreset_first_beat got=%b%b%b_%0h exp=110_1234", m_tvalid, m_tuser,
               m_tlast, m_tdata);
    end
  endtask

`ifdef BARREL_FRAMER_STATS_EN
  task automatic test_stats();
    do_reset();
    run_traffic(2 * FRAME, 2 * FRAME, 100, 100, 2, 7);
    step();
    checks++;
    if (frame_count !== 16'd2) begin
      failures++;
      $display("FAIL stats_frames got=%0d exp=2", frame_count);
    end
    checks++;
    if (stall_cycles !== 32'd7) begin
      failures++;
      $display("FAIL stats_stalls got=%0d exp=7", stall_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_framing();
    test_random_backpressure();
    test_reset_mid_frame();
`ifdef BARREL_FRAMER_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

endmodule
